data_ram_resp: RTL and testbench

- Data-memory responder on the memory-stage load/store bus; the memory stage is the initiator.
- Holds a word-organised, byte-writable RAM and services one request at a time with a configurable wait-state count.
- Returns an ack and read data.
- Drives a stall request so the pipeline freezes the memory stage until the access completes.

---
 rtl/data_ram_resp.sv | 157 +++++++++++++++
 tb/tb_data_ram_resp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_resp.sv
// data_ram_resp
//   Data-memory responder for the memory-stage load/store bus. It holds a
//   word-organised, byte-writable RAM. It services one request at a time and
//   inserts WAIT_CYCLES wait states between accepting a request and
//   committing it. On completion it returns a one-cycle ack and, for loads,
//   the lane-masked read data. While a request is outstanding it raises a
//   stall request so the pipeline holds the memory stage.
//
// Parameters
//   ADDR_W      log2 of RAM depth in 32-bit words
//   WAIT_CYCLES cycles between acceptance and commit (0..15)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   mem_ce_i    request valid; the initiator holds it and all fields until ack
//   mem_we_i    1 = store, 0 = load
//   mem_addr_i  byte address; word index = mem_addr_i[ADDR_W+1:2]
//   mem_sel_i   byte lane enables, sel[3] = data[31:24]
//   mem_data_i  store data, lane aligned
//   mem_data_o  registered load data (unselected lanes zero)
//   mem_ack_o   registered one-cycle completion pulse
//   stallreq_o  combinational pipeline stall request
module data_ram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);
  localparam int         LP_DEPTH = 1 << ADDR_W;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic                w_commit;
  logic [ADDR_W-1:0]   w_idx;
  logic [31:0]         w_lane_mask;
  logic [31:0]         r_mem [0:LP_DEPTH-1];
  logic [31:0]         r_data;
  logic                r_ack;
  logic                w_unused;

  // Byte offset and address bits above the RAM size are dropped, so
  // accesses wrap modulo the RAM size in bytes.
  assign w_idx    = mem_addr_i[ADDR_W+1:2];
  assign w_unused = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign w_lane_mask[gi*8 +: 8] = {8{mem_sel_i[gi]}};
    end
  endgenerate

  // Next-state logic. w_commit marks the edge at which the access takes
  // effect on the RAM or on the read-data register.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_ce_i) begin
          w_cnt_next = LP_WAIT;
          if (WAIT_CYCLES == 0) begin
            w_commit     = 1'b1;
            w_state_next = S_ACK;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!mem_ce_i) begin
          // Initiator withdrew the request: drop it without committing.
          w_state_next = S_IDLE;
        end else if (r_cnt > 4'd1) begin
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_commit     = 1'b1;
          w_state_next = S_ACK;
        end
      end
      S_ACK: begin
        // Request inputs are ignored here; the pipeline advances this cycle.
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // A reset edge drops any pending access with nothing committed.
    if (rst) begin
      w_commit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // RAM write port: kept free of reset so it maps onto block RAM with
  // per-byte write enables.
  always_ff @(posedge clk) begin
    if (w_commit && mem_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_sel_i[b]) begin
          r_mem[w_idx][b*8 +: 8] <= mem_data_i[b*8 +: 8];
        end
      end
    end
  end

  // Registered read and ack. The read register only updates on a load
  // commit, so it holds its value across stores and idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack  <= 1'b0;
      r_data <= 32'h0;
    end else begin
      r_ack <= (w_state_next == S_ACK);
      if (w_commit && !mem_we_i) begin
        r_data <= r_mem[w_idx] & w_lane_mask;
      end
    end
  end

  assign mem_ack_o  = r_ack;
  assign mem_data_o = r_data;
  // Low in the ack cycle so the memory stage advances exactly then.
  assign stallreq_o = mem_ce_i & (r_state != S_ACK) & ~rst;

endmodule

// File: tb/tb_data_ram_resp.sv
// Testbench for data_ram_resp. It runs three instances that share clk and
// rst, built with WAIT_CYCLES = 1, 3 and 0. Each instance has its own
// request signals.
module tb_data_ram_resp;

  logic        clk;
  logic        rst;
  logic        ce    [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [3:0]  sel   [3];
  logic [31:0] din   [3];
  logic [31:0] dout  [3];
  logic        ack   [3];
  logic        stall [3];

  int checks;
  int failures;

  logic [31:0] model_mem [3][1024];
  logic [31:0] last_load [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      data_ram_resp #(
        .ADDR_W     (10),
        .WAIT_CYCLES((gi == 0) ? 1 : ((gi == 1) ? 3 : 0))
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mem_ce_i  (ce[gi]),
        .mem_we_i  (we[gi]),
        .mem_addr_i(addr[gi]),
        .mem_sel_i (sel[gi]),
        .mem_data_i(din[gi]),
        .mem_data_o(dout[gi]),
        .mem_ack_o (ack[gi]),
        .stallreq_o(stall[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    if (s[3]) m = m | 32'hFF00_0000;
    if (s[2]) m = m | 32'h00FF_0000;
    if (s[1]) m = m | 32'h0000_FF00;
    if (s[0]) m = m | 32'h0000_00FF;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One complete access on instance k. The request is presented in cycle N.
  // The task checks ack latency, the stall duration, that stall is low in
  // the ack cycle, and that the ack lasts exactly one cycle.
  task automatic do_access(input int k, input bit w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d,
                           output logic [31:0] rdata);
    int lat;
    int stalls;
    bit got;
    @(negedge clk);
    ce[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; din[k] = d;
    #1;
    stalls = stall[k] ? 1 : 0;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      #1;
      if (ack[k]) begin
        got = 1'b1;
        lat = i;
        break;
      end
      if (stall[k]) stalls++;
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (got) begin
      chk("ack_latency", 32'(lat), 32'(1 + wc(k)));
      chk("stall_cycles", 32'(stalls), 32'(1 + wc(k)));
      chk("stall_in_ack", 32'(stall[k]), 32'd0);
    end
    rdata = dout[k];
    ce[k] = 1'b0;
    @(negedge clk);
    #1;
    chk("ack_one_cycle", 32'(ack[k]), 32'd0);
    $display("txn inst=%0d %s addr=%h sel=%b wdata=%h lat=%0d rdata=%h",
             k, w ? "ST" : "LD", a, s, d, lat, rdata);
  endtask

  // Model-checked access: a store updates the model and must leave the read
  // register unchanged; a load must return the lane-masked model word.
  task automatic model_access(input int k, input bit w, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] d);
    logic [31:0] r;
    int idx;
    idx = int'(a[11:2]);
    do_access(k, w, a, s, d, r);
    if (w) begin
      model_mem[k][idx] = (model_mem[k][idx] & ~lane_mask(s)) | (d & lane_mask(s));
      chk("store_keeps_rdata", r, last_load[k]);
    end else begin
      chk("load_data", r, model_mem[k][idx] & lane_mask(s));
      last_load[k] = model_mem[k][idx] & lane_mask(s);
    end
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    checks = 0;
    failures = 0;
    for (int k = 0; k < 3; k++) last_load[k] = 32'h0;

    // Directed vectors for instance 0. For a store, exp is the unchanged read data.
    vecs[0]  = '{1'b1, 32'h0000_0040, 4'b1111, 32'h1234_5678, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0040, 4'b1111, 32'h0,         32'h1234_5678};
    vecs[2]  = '{1'b1, 32'h0000_0040, 4'b0100, 32'hAABB_CCDD, 32'h1234_5678};
    vecs[3]  = '{1'b0, 32'h0000_0040, 4'b0011, 32'h0,         32'h0000_5678};
    vecs[4]  = '{1'b0, 32'h0000_0040, 4'b1000, 32'h0,         32'h1200_0000};
    vecs[5]  = '{1'b0, 32'h0000_0040, 4'b1111, 32'h0,         32'h12BB_5678};
    vecs[6]  = '{1'b1, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 32'h12BB_5678};
    vecs[7]  = '{1'b0, 32'h0000_0004, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vecs[8]  = '{1'b0, 32'h0000_0007, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 32'h0000_0040, 4'b0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 32'h0000_0040, 4'b1111, 32'h0,         32'h12BB_5678};

    // Reset held with requests asserted: no ack, zero data, no stall.
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ce[k] = 1'b1; we[k] = 1'b1; addr[k] = 32'h100; sel[k] = 4'hF; din[k] = 32'h5A5A_5A5A;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (c > 0) begin
        for (int k = 0; k < 3; k++) begin
          chk("rst_ack", 32'(ack[k]), 32'd0);
          chk("rst_data", dout[k], 32'h0);
          chk("rst_stall", 32'(stall[k]), 32'd0);
        end
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) ce[k] = 1'b0;
    @(negedge clk);

    // Table-driven directed sequence on the WAIT_CYCLES=1 instance.
    for (int v = 0; v < 11; v++) begin
      do_access(0, vecs[v].w, vecs[v].a, vecs[v].s, vecs[v].d, r);
      chk($sformatf("vec%0d_data", v), r, vecs[v].exp);
    end
    last_load[0] = 32'h12BB_5678;

    // Abort on the WAIT_CYCLES=3 instance: withdraw in the second wait cycle.
    do_access(1, 1'b1, 32'h80, 4'hF, 32'hCAFE_F00D, r);
    @(negedge clk);
    ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h80; sel[1] = 4'hF; din[1] = 32'h0BAD_BEEF;
    @(negedge clk);   // first wait cycle
    @(negedge clk);   // second wait cycle
    ce[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk("abort_no_ack", 32'(ack[1]), 32'd0);
    end
    do_access(1, 1'b0, 32'h80, 4'hF, 32'h0, r);
    chk("abort_no_write", r, 32'hCAFE_F00D);

    // Reset during the wait phase of a store.
    do_access(1, 1'b1, 32'h100, 4'hF, 32'h1111_1111, r);
    @(negedge clk);
    ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h100; sel[1] = 4'hF; din[1] = 32'h2222_2222;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_stall", 32'(stall[1]), 32'd0);
    @(negedge clk);
    #1;
    chk("midrst_ack", 32'(ack[1]), 32'd0);
    chk("midrst_data", dout[1], 32'h0);
    rst = 1'b0;
    ce[1] = 1'b0;
    for (int k = 0; k < 3; k++) last_load[k] = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("midrst_no_ack", 32'(ack[1]), 32'd0);
    end
    do_access(1, 1'b0, 32'h100, 4'hF, 32'h0, r);
    chk("midrst_no_write", r, 32'h1111_1111);
    last_load[1] = 32'h1111_1111;

    // Zero wait states: one-cycle latency, then back-to-back with ce held.
    do_access(2, 1'b1, 32'h300, 4'hF, 32'h0102_0304, r);
    do_access(2, 1'b0, 32'h300, 4'hF, 32'h0, r);
    chk("w0_load", r, 32'h0102_0304);
    @(negedge clk);
    ce[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h300; sel[2] = 4'hF;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("cont_ack_c%0d", c), 32'(ack[2]), 32'(c % 2));
      if (ack[2]) chk("cont_data", dout[2], 32'h0102_0304);
    end
    ce[2] = 1'b0;
    last_load[2] = 32'h0102_0304;
    @(negedge clk);

    // Random accesses on all instances against the array model. Random high
    // and low address bits exercise wrap-around and offset ignoring.
    for (int k = 0; k < 3; k++) begin
      for (int wi = 0; wi < 8; wi++) begin
        a = $urandom;
        a[11:2] = 10'(128 + wi);
        model_access(k, 1'b1, a, 4'hF, $urandom);
      end
      for (int t = 0; t < 30; t++) begin
        a = $urandom;
        a[11:2] = 10'(128 + $urandom_range(0, 7));
        model_access(k, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
